// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access controller and its arbiter.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PIPE_BUSY = 2'd1,
      DMA_BUSY  = 2'd2
   } dmem_state_e;

   localparam logic [1:0] BYTE = 2'b00;
   localparam logic [1:0] HALF = 2'b01;
   localparam logic [1:0] WORD = 2'b10;

   // Bit positions of the load/store flags inside the MEM-stage control word.
   localparam int MEMREAD  = 4;
   localparam int MEMWRITE = 3;

   // A request with both flags set is illegal and is treated as a read.
   function automatic logic pipe_is_write(input logic rd, input logic wr);
      return wr & ~rd;
   endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational IDLE-state selector between the pipeline and the DMA port.
module dmem_arb_pick (
   input  logic pipe_req,
   input  logic dma_req,
   input  logic starve_hit,
   output logic grant_pipe,
   output logic grant_dma
);

   logic force_dma;

   // A starved DMA request overrides the pipeline; otherwise the pipeline wins.
   assign force_dma  = dma_req & starve_hit;
   assign grant_pipe = pipe_req & ~force_dma;
   assign grant_dma  = dma_req & (force_dma | ~pipe_req);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Shares a single-port data memory between the MEM stage and a DMA/debug port,
// adding fixed memory latency and bounding how long DMA can be starved.
module dmem_access_ctrl
   import dmem_pkg::*;
#(
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        pipe_read,
   input  logic        pipe_write,
   input  logic [1:0]  pipe_size,
   input  logic [31:0] pipe_addr,
   input  logic [31:0] pipe_wdata,
   output logic        pipe_stall,
   output logic [31:0] pipe_rdata,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   output logic        dma_gnt,
   output logic        dma_rvalid,
   output logic [31:0] dma_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [1:0]  mem_ctrl,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam int CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
   localparam int STARVE_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;

   dmem_state_e         state;
   logic [CNT_W-1:0]    cnt;
   logic [STARVE_W-1:0] starve_cnt;
   logic [31:0]         lat_addr;
   logic [31:0]         lat_wdata;
   logic                lat_we;
   logic [1:0]          lat_size;

   logic pipe_req;
   logic starve_hit;
   logic grant_pipe;
   logic grant_dma;
   logic busy;
   logic first_cycle;
   logic pipe_done;

   assign pipe_req   = pipe_read | pipe_write;
   assign starve_hit = (starve_cnt == STARVE_W'(STARVE_MAX));

   dmem_arb_pick u_pick (
      .pipe_req   (pipe_req),
      .dma_req    (dma_req),
      .starve_hit (starve_hit),
      .grant_pipe (grant_pipe),
      .grant_dma  (grant_dma)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         starve_cnt <= '0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_we     <= 1'b0;
         lat_size   <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (grant_pipe) begin
                  lat_addr  <= pipe_addr;
                  lat_wdata <= pipe_wdata;
                  lat_we    <= pipe_is_write(pipe_read, pipe_write);
                  lat_size  <= pipe_size;
                  cnt       <= CNT_W'(MEM_LAT);
                  state     <= PIPE_BUSY;
                  if (dma_req && !starve_hit)
                     starve_cnt <= starve_cnt + STARVE_W'(1);
               end else if (grant_dma) begin
                  lat_addr   <= dma_addr;
                  lat_wdata  <= dma_wdata;
                  lat_we     <= dma_we;
                  lat_size   <= WORD;
                  cnt        <= CNT_W'(MEM_LAT);
                  state      <= DMA_BUSY;
                  starve_cnt <= '0;
               end
               // Starvation only accumulates while DMA is actually waiting.
               if (!dma_req)
                  starve_cnt <= '0;
            end
            PIPE_BUSY, DMA_BUSY: begin
               if (cnt == '0)
                  state <= IDLE;
               else
                  cnt <= cnt - CNT_W'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy        = (state != IDLE);
   assign first_cycle = busy && (cnt == CNT_W'(MEM_LAT));
   assign pipe_done   = (state == PIPE_BUSY) && (cnt == '0);

   // The memory sees the request for exactly one cycle; the bus is quiet otherwise.
   assign mem_en    = first_cycle;
   assign mem_we    = first_cycle & lat_we;
   assign mem_ctrl  = first_cycle ? lat_size  : 2'b00;
   assign mem_addr  = first_cycle ? lat_addr  : 32'h0;
   assign mem_wdata = first_cycle ? lat_wdata : 32'h0;

   assign pipe_stall = pipe_req & ~pipe_done;
   assign pipe_rdata = pipe_done ? mem_rdata : 32'h0;

   assign dma_gnt    = (state == IDLE) & grant_dma;
   assign dma_rvalid = (state == DMA_BUSY) && (cnt == '0);
   assign dma_rdata  = (dma_rvalid && !lat_we) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a two-cycle-latency memory model.
module tb_dmem_access_ctrl;
   import dmem_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        pipe_read, pipe_write;
   logic [1:0]  pipe_size;
   logic [31:0] pipe_addr, pipe_wdata;
   logic        pipe_stall;
   logic [31:0] pipe_rdata;
   logic        dma_req, dma_we;
   logic [31:0] dma_addr, dma_wdata;
   logic        dma_gnt, dma_rvalid;
   logic [31:0] dma_rdata;
   logic        mem_en, mem_we;
   logic [1:0]  mem_ctrl;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = 32'h0;
   logic [31:0] rd_stage  = 32'h0;

   int errors = 0;
   int checks = 0;

   dmem_access_ctrl #(.MEM_LAT(2), .STARVE_MAX(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .pipe_read  (pipe_read),
      .pipe_write (pipe_write),
      .pipe_size  (pipe_size),
      .pipe_addr  (pipe_addr),
      .pipe_wdata (pipe_wdata),
      .pipe_stall (pipe_stall),
      .pipe_rdata (pipe_rdata),
      .dma_req    (dma_req),
      .dma_we     (dma_we),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_gnt    (dma_gnt),
      .dma_rvalid (dma_rvalid),
      .dma_rdata  (dma_rdata),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_ctrl   (mem_ctrl),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_model(input logic [31:0] a);
      return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
   endfunction

   // Read data appears two edges after the edge that samples mem_en.
   always @(posedge clk) begin
      rd_stage  <= (mem_en && !mem_we) ? mem_model(mem_addr) : 32'h0;
      mem_rdata <= rd_stage;
   end

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0;
      pipe_read = 1'b0; pipe_write = 1'b0; pipe_size = 2'b00;
      pipe_addr = 32'h0; pipe_wdata = 32'h0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;

      // Reset state and idle behaviour
      tick(); tick(); settle();
      check1 ("rst_mem_en",     mem_en,     1'b0);
      check1 ("rst_mem_we",     mem_we,     1'b0);
      check32("rst_mem_ctrl",   32'(mem_ctrl), 32'h0);
      check32("rst_mem_addr",   mem_addr,   32'h0);
      check32("rst_mem_wdata",  mem_wdata,  32'h0);
      check1 ("rst_dma_gnt",    dma_gnt,    1'b0);
      check1 ("rst_dma_rvalid", dma_rvalid, 1'b0);
      check32("rst_dma_rdata",  dma_rdata,  32'h0);
      check32("rst_pipe_rdata", pipe_rdata, 32'h0);
      check1 ("rst_stall",      pipe_stall, 1'b0);
      pipe_read = 1'b1; #1;
      check1 ("rst_stall_follow_hi", pipe_stall, 1'b1);
      pipe_read = 1'b0; #1;
      check1 ("rst_stall_follow_lo", pipe_stall, 1'b0);
      tick(); reset_n = 1'b1; settle();
      check1 ("idle_mem_en",  mem_en,  1'b0);
      check1 ("idle_dma_gnt", dma_gnt, 1'b0);

      // Pipe load @0x100
      tick(); pipe_read = 1'b1; pipe_addr = 32'h100; pipe_size = WORD; settle();
      check1 ("ld_c0_stall", pipe_stall, 1'b1);
      check1 ("ld_c0_en",    mem_en,     1'b0);
      tick(); settle();
      check1 ("ld_c1_stall", pipe_stall, 1'b1);
      check1 ("ld_c1_en",    mem_en,     1'b1);
      check1 ("ld_c1_we",    mem_we,     1'b0);
      check32("ld_c1_addr",  mem_addr,   32'h100);
      tick(); settle();
      check1 ("ld_c2_stall", pipe_stall, 1'b1);
      check1 ("ld_c2_en",    mem_en,     1'b0);
      check32("ld_c2_addr",  mem_addr,   32'h0);
      tick(); settle();
      check1 ("ld_c3_stall", pipe_stall, 1'b0);
      check32("ld_c3_rdata", pipe_rdata, 32'hDEADBEEF);
      tick(); pipe_read = 1'b0; settle();
      check32("ld_c4_rdata", pipe_rdata, 32'h0);
      check1 ("ld_c4_stall", pipe_stall, 1'b0);

      // Pipe store, HALF @0x40
      tick(); pipe_write = 1'b1; pipe_size = HALF; pipe_addr = 32'h40; pipe_wdata = 32'h12345678; settle();
      check1 ("st_c0_stall", pipe_stall, 1'b1);
      tick(); settle();
      check1 ("st_c1_en",    mem_en,     1'b1);
      check1 ("st_c1_we",    mem_we,     1'b1);
      check32("st_c1_ctrl",  32'(mem_ctrl), 32'h1);
      check32("st_c1_addr",  mem_addr,   32'h40);
      check32("st_c1_wdata", mem_wdata,  32'h12345678);
      tick(); settle();
      check1 ("st_c2_stall", pipe_stall, 1'b1);
      check1 ("st_c2_we",    mem_we,     1'b0);
      tick(); settle();
      check1 ("st_c3_stall", pipe_stall, 1'b0);
      tick(); pipe_write = 1'b0; pipe_size = WORD; settle();

      // DMA read @0x200, pipeline idle
      tick(); dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h200; settle();
      check1 ("dr_c0_gnt", dma_gnt, 1'b1);
      check1 ("dr_c0_stall", pipe_stall, 1'b0);
      tick(); dma_req = 1'b0; settle();
      check1 ("dr_c1_gnt",  dma_gnt,  1'b0);
      check1 ("dr_c1_en",   mem_en,   1'b1);
      check32("dr_c1_ctrl", 32'(mem_ctrl), 32'h2);
      check32("dr_c1_addr", mem_addr, 32'h200);
      tick(); settle();
      check1 ("dr_c2_rvalid", dma_rvalid, 1'b0);
      tick(); settle();
      check1 ("dr_c3_rvalid", dma_rvalid, 1'b1);
      check32("dr_c3_rdata",  dma_rdata,  32'hA5A50200);
      tick(); settle();
      check1 ("dr_c4_rvalid", dma_rvalid, 1'b0);

      // Simultaneous pipe read and DMA with starve_cnt=0: pipe first
      tick(); pipe_read = 1'b1; pipe_addr = 32'h300; dma_req = 1'b1; dma_addr = 32'h400; settle();
      check1 ("sim_c0_gnt",   dma_gnt,    1'b0);
      check1 ("sim_c0_stall", pipe_stall, 1'b1);
      tick(); settle();
      check32("sim_c1_addr",  mem_addr,   32'h300);
      tick(); tick(); settle();
      check1 ("sim_c3_stall", pipe_stall, 1'b0);
      check32("sim_c3_rdata", pipe_rdata, 32'hA5A50300);
      tick(); pipe_read = 1'b0; settle();
      check1 ("sim_c4_gnt",   dma_gnt,    1'b1);
      tick(); dma_req = 1'b0; settle();
      check32("sim_c5_addr",  mem_addr,   32'h400);
      tick(); tick(); settle();
      check1 ("sim_c7_rvalid", dma_rvalid, 1'b1);
      check32("sim_c7_rdata",  dma_rdata,  32'hA5A50400);

      // Starvation: continuous pipe loads while a DMA write waits
      tick();
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h500; dma_wdata = 32'hCAFEF00D;
      pipe_read = 1'b1; pipe_addr = 32'h600;
      for (int k = 0; k < 4; k++) begin
         settle();
         check1 ($sformatf("stv_gnt%0d", k), dma_gnt, 1'b0);
         tick(); settle();
         check32($sformatf("stv_addr%0d", k), mem_addr, 32'h600 + 32'(4 * k));
         tick(); tick(); settle();
         check32($sformatf("stv_rdata%0d", k), pipe_rdata, mem_model(32'h600 + 32'(4 * k)));
         tick(); pipe_addr = 32'h600 + 32'(4 * (k + 1));
      end
      settle();
      check1 ("stv_force_gnt",   dma_gnt,    1'b1);
      check1 ("stv_force_stall", pipe_stall, 1'b1);
      tick(); dma_req = 1'b0; settle();
      check1 ("stv_dw_we",    mem_we,    1'b1);
      check32("stv_dw_ctrl",  32'(mem_ctrl), 32'h2);
      check32("stv_dw_addr",  mem_addr,  32'h500);
      check32("stv_dw_wdata", mem_wdata, 32'hCAFEF00D);
      tick(); tick(); settle();
      check1 ("stv_dw_rvalid", dma_rvalid, 1'b1);
      check32("stv_dw_rdata",  dma_rdata,  32'h0);
      check1 ("stv_dw_stall",  pipe_stall, 1'b1);
      tick(); settle();
      check1 ("stv_resume_gnt", dma_gnt, 1'b0);
      check1 ("stv_resume_en0", mem_en,  1'b0);
      tick(); settle();
      check1 ("stv_resume_en1",  mem_en,   1'b1);
      check32("stv_resume_addr", mem_addr, 32'h610);
      tick(); tick(); settle();
      check32("stv_resume_rdata", pipe_rdata, 32'hA5A50610);
      tick(); pipe_read = 1'b0; dma_we = 1'b0; settle();

      // Reset pulsed during PIPE_BUSY with cnt=1
      tick(); pipe_read = 1'b1; pipe_addr = 32'h100; settle();
      tick(); settle();
      check1 ("rm_c1_en", mem_en, 1'b1);
      tick(); settle();
      reset_n = 1'b0; pipe_read = 1'b0; #1;
      check1 ("rm_stall",  pipe_stall, 1'b0);
      check1 ("rm_en",     mem_en,     1'b0);
      check32("rm_rdata",  pipe_rdata, 32'h0);
      tick(); reset_n = 1'b1; settle();
      check32("rm_c3_rdata",  pipe_rdata, 32'h0);
      check1 ("rm_c3_rvalid", dma_rvalid, 1'b0);
      check1 ("rm_c3_en",     mem_en,     1'b0);
      tick(); pipe_read = 1'b1; pipe_addr = 32'h104; settle();
      tick(); settle();
      check1 ("rm_after_en",   mem_en,   1'b1);
      check32("rm_after_addr", mem_addr, 32'h104);
      tick(); tick(); settle();
      check32("rm_after_rdata", pipe_rdata, 32'hA5A50104);
      tick(); pipe_read = 1'b0; settle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
